// File: rtl/io_mailbox.sv
// io_mailbox: CPU I/O-bus byte mailbox with a TX FIFO toward a stream consumer,
// an RX FIFO from a stream producer, a status/control register and a level IRQ.
module io_mailbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  // Full/empty guards use the pre-cycle flags, so a push into a full FIFO is
  // refused even if the same cycle pops.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rp];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

module io_mailbox #(
  parameter int fifo_depth = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_addr,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        intr
);
  logic        r_ack, r_irq_en, r_ovf, r_intr;
  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [7:0]  w_tx_head, w_rx_head;
  logic        w_data_wr, w_data_rd, w_stat_wr;
  logic [15:0] w_status;

  // Every side effect is qualified by r_ack, so each access acts exactly once.
  assign w_data_wr = r_ack & data_m_wr_en & ~data_m_addr & data_m_bytesel[0];
  assign w_data_rd = r_ack & ~data_m_wr_en & ~data_m_addr;
  assign w_stat_wr = r_ack & data_m_wr_en & data_m_addr & data_m_bytesel[0];
  assign w_status  = {11'b0, r_irq_en, r_ovf, w_tx_empty, w_tx_full, ~w_rx_empty};

  io_mailbox_fifo #(.DEPTH(fifo_depth)) u_tx (
    .clk(clk), .reset(reset),
    .i_push(w_data_wr), .i_data(data_m_data_in[7:0]), .i_pop(tx_ready),
    .o_head(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

  io_mailbox_fifo #(.DEPTH(fifo_depth)) u_rx (
    .clk(clk), .reset(reset),
    .i_push(rx_valid), .i_data(rx_data), .i_pop(w_data_rd),
    .o_head(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  assign data_m_ack = r_ack;
  assign tx_valid   = ~w_tx_empty;
  assign tx_data    = w_tx_empty ? 8'h00 : w_tx_head;
  assign rx_ready   = ~w_rx_full;
  assign intr       = r_intr;

  always_comb begin
    data_m_data_out = '0;
    if (r_ack && !data_m_wr_en)
      data_m_data_out = data_m_addr ? w_status : (w_rx_empty ? 16'h0000 : {8'h00, w_rx_head});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_intr   <= 1'b0;
    end else begin
      r_ack  <= cs & data_m_access & ~r_ack;
      r_intr <= r_irq_en & ~w_rx_empty;
      if (w_data_wr && w_tx_full) r_ovf <= 1'b1;
      if (w_stat_wr) begin
        r_irq_en <= data_m_data_in[4];
        if (data_m_data_in[3]) r_ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_io_mailbox.sv
// Bench for io_mailbox: directed scenarios plus random traffic, all cycles
// checked against a queue-based model of the mailbox.
module tb_io_mailbox;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, data_m_access = 1'b0, data_m_addr = 1'b0, data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = 2'b00;
  logic [15:0] data_m_data_in = 16'h0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        data_m_ack, tx_valid, rx_ready, intr;
  logic [15:0] data_m_data_out;
  logic [7:0]  tx_data;

  io_mailbox #(.fifo_depth(D)) dut (
    .clk(clk), .reset(reset), .cs(cs), .data_m_access(data_m_access),
    .data_m_ack(data_m_ack), .data_m_addr(data_m_addr), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_data_in(data_m_data_in),
    .data_m_data_out(data_m_data_out), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .intr(intr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]  mtx[$], mrx[$], prod_q[$], cap[$];
  bit          m_ack, m_ovf, m_irq, m_intr, saw_ack;
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mtx.delete(); mrx.delete();
    m_ack = 0; m_ovf = 0; m_irq = 0; m_intr = 0;
  endtask

  function automatic logic [15:0] model_rd(input logic a);
    if (!a) return (mrx.size() != 0) ? {8'h00, mrx[0]} : 16'h0000;
    return {11'b0, m_irq, m_ovf, 1'(mtx.size() == 0), 1'(mtx.size() == D), 1'(mrx.size() != 0)};
  endfunction

  task automatic prod_drive();
    rx_valid = (prod_q.size() != 0);
    rx_data  = (prod_q.size() != 0) ? prod_q[0] : 8'h00;
  endtask

  // One clock: check outputs at negedge, advance the model at posedge, re-drive producer.
  task automatic tick();
    bit txp, cpu_dw, cpu_dr, sw, rxp, n_intr, n_ack, txfull, pacc;
    logic [7:0]  din;
    logic [15:0] sdat;
    @(negedge clk);
    saw_ack = data_m_ack;
    chk("ack", 16'(data_m_ack), 16'(m_ack));
    if (!m_ack) chk("dout_idle", data_m_data_out, 16'h0000);
    else if (!data_m_wr_en) chk("dout_rd", data_m_data_out, model_rd(data_m_addr));
    chk("tx_valid", 16'(tx_valid), 16'(mtx.size() != 0));
    chk("tx_data", 16'(tx_data), (mtx.size() != 0) ? 16'(mtx[0]) : 16'h0);
    chk("rx_ready", 16'(rx_ready), 16'(mrx.size() < D));
    chk("intr", 16'(intr), 16'(m_intr));
    if (data_m_ack && !data_m_wr_en) last_rd = data_m_data_out;
    if (tx_valid && tx_ready && !reset) cap.push_back(tx_data);
    pacc   = rx_valid && rx_ready && !reset;
    txp    = (mtx.size() != 0) && tx_ready;
    cpu_dw = m_ack && data_m_wr_en && !data_m_addr && data_m_bytesel[0];
    cpu_dr = m_ack && !data_m_wr_en && !data_m_addr && (mrx.size() != 0);
    sw     = m_ack && data_m_wr_en && data_m_addr && data_m_bytesel[0];
    rxp    = rx_valid && (mrx.size() < D);
    n_intr = m_irq && (mrx.size() != 0);
    n_ack  = cs && data_m_access && !m_ack;
    txfull = (mtx.size() == D);
    din    = data_m_data_in[7:0];
    sdat   = data_m_data_in;
    @(posedge clk);
    if (reset) model_clear();
    else begin
      if (txp) void'(mtx.pop_front());
      if (cpu_dw) begin
        if (txfull) m_ovf = 1;
        else mtx.push_back(din);
      end
      if (cpu_dr) void'(mrx.pop_front());
      if (rxp) mrx.push_back(rx_data);
      if (sw) begin
        m_irq = sdat[4];
        if (sdat[3]) m_ovf = 0;
      end
      m_intr = n_intr;
      m_ack  = n_ack;
    end
    #1;
    if (pacc) void'(prod_q.pop_front());
    prod_drive();
  endtask

  task automatic cpu(input bit wr, input bit a, input logic [1:0] bs, input logic [15:0] d);
    int n = 0;
    cs = 1; data_m_access = 1; data_m_wr_en = wr; data_m_addr = a;
    data_m_bytesel = bs; data_m_data_in = d;
    saw_ack = 0;
    while (!saw_ack && n < 8) begin tick(); n++; end
    chk("ack_bound", 16'(saw_ack), 16'h1);
    cs = 0; data_m_access = 0;
  endtask

  initial begin
    int busy;
    model_clear();
    // Reset and status read
    tick(); tick();
    reset = 0;
    tick();
    cpu(0, 1, 2'b01, 16'h0);
    chk("rst_status", last_rd, 16'h0004);
    chk("rst_rx_ready", 16'(rx_ready), 16'h1);

    // Nine TX writes with consumer stalled, then drain
    for (int i = 0; i < 9; i++) cpu(1, 0, 2'b01, 16'h0041 + 16'(i));
    cpu(0, 1, 2'b01, 16'h0);
    chk("tx_full_status", last_rd, 16'h000A);
    cap.delete();
    tx_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    tx_ready = 0;
    chk("tx_drain_cnt", 16'(cap.size()), 16'd8);
    for (int i = 0; i < 8 && i < cap.size(); i++) chk("tx_order", 16'(cap[i]), 16'h0041 + 16'(i));

    // IRQ with two RX bytes
    cpu(1, 1, 2'b01, 16'h0010);
    prod_q.push_back(8'h55); prod_q.push_back(8'hAA); prod_drive();
    tick(); tick(); tick();
    chk("intr_rise", 16'(intr), 16'h1);
    cpu(0, 0, 2'b01, 16'h0);
    chk("rx_rd0", last_rd, 16'h0055);
    cpu(0, 0, 2'b01, 16'h0);
    chk("rx_rd1", last_rd, 16'h00AA);
    tick();
    chk("intr_fall", 16'(intr), 16'h0);
    cpu(0, 0, 2'b01, 16'h0);
    chk("rx_rd_empty", last_rd, 16'h0000);

    // Fill RX, then pop while producer is held
    for (int i = 0; i < 9; i++) prod_q.push_back(8'h10 + 8'(i));
    prod_drive();
    for (int i = 0; i < 12; i++) tick();
    chk("rx_full_ready", 16'(rx_ready), 16'h0);
    cpu(0, 0, 2'b01, 16'h0);
    chk("rx_full_rd", last_rd, 16'h0010);
    tick();
    chk("rx_refill", 16'(rx_ready), 16'h0);
    for (int i = 0; i < 8; i++) begin
      cpu(0, 0, 2'b01, 16'h0);
      chk("rx_drain", last_rd, 16'h0011 + 16'(i));
    end

    // TX full with a pop in the same cycle as the CPU write
    cpu(1, 1, 2'b01, 16'h0018);
    for (int i = 0; i < 8; i++) cpu(1, 0, 2'b01, 16'h0060 + 16'(i));
    cs = 1; data_m_access = 1; data_m_wr_en = 1; data_m_addr = 0;
    data_m_bytesel = 2'b01; data_m_data_in = 16'h0077;
    tick();
    tx_ready = 1;
    tick();
    chk("full_pop_ack", 16'(saw_ack), 16'h1);
    cs = 0; data_m_access = 0; tx_ready = 0;
    cpu(0, 1, 2'b01, 16'h0);
    chk("ovf_set", last_rd, 16'h0018);
    cpu(1, 1, 2'b01, 16'h0008);
    cpu(0, 1, 2'b01, 16'h0);
    chk("ovf_clr", last_rd, 16'h0000);
    tx_ready = 1;
    for (int i = 0; i < 10; i++) tick();
    tx_ready = 0;

    // Reset in the middle of an access
    for (int i = 0; i < 3; i++) cpu(1, 0, 2'b01, 16'h0031 + 16'(i));
    cs = 1; data_m_access = 1; data_m_wr_en = 0; data_m_addr = 1; data_m_bytesel = 2'b01;
    #2 reset = 1;
    #1 model_clear();
    chk("mid_rst_txv", 16'(tx_valid), 16'h0);
    tick();
    chk("mid_rst_ack", 16'(data_m_ack), 16'h0);
    cs = 0; data_m_access = 0;
    reset = 0;
    tick();
    cpu(0, 1, 2'b01, 16'h0);
    chk("post_rst_status", last_rd, 16'h0004);

    // Random traffic
    busy = 0;
    for (int c = 0; c < 800; c++) begin
      if (busy != 0) begin
        if (saw_ack || !cs) begin
          cs = 0; data_m_access = 0; busy = 0;
        end else begin
          busy++;
          chk("rnd_ack_bound", 16'(busy <= 8), 16'h1);
        end
      end else if ($urandom_range(2) == 0) begin
        cs = ($urandom_range(7) != 0);
        data_m_access = 1;
        data_m_wr_en = 1'($urandom_range(1));
        data_m_addr = 1'($urandom_range(1));
        data_m_bytesel = 2'($urandom_range(3));
        data_m_data_in = 16'($urandom);
        busy = 1;
      end
      tx_ready = 1'($urandom_range(1));
      if (prod_q.size() == 0 && $urandom_range(1) == 1) begin
        prod_q.push_back(8'($urandom));
        prod_drive();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
